i2c_cmd_arbiter: RTL and testbench

Shares one byte-level I2C master command engine among NUM_REQ requesters (test sequences, register-init agents). Arbitrates round-robin at transaction granularity: a grant is held from the requester's START through completion of its STOP. Forwards one command at a time to the engine and routes the engine's response back to the owner. Cleans up abandoned transactions and reports NAK, arbitration-loss and protocol errors.

---
 rtl/i2c_cmd_arbiter_pkg.sv | 24 ++
 rtl/i2c_rr_picker.sv | 34 +++
 rtl/i2c_cmd_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared types for the I2C command arbiter: engine command encoding and arbiter FSM states.
package i2c_cmd_arbiter_pkg;

    typedef enum logic [2:0] {
        CmdStart   = 3'd0,
        CmdStop    = 3'd1,
        CmdWrite   = 3'd2,
        CmdReadAck = 3'd3,
        CmdReadNak = 3'd4
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        StIdle,
        StOwned,
        StWait,
        StForceStop,
        StRelease
    } i2c_arb_state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin first-one finder: first set request at or after the pointer, wrapping.
module i2c_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [NUM_REQ-1:0] w_rot;
    int unsigned        w_sel;

    always_comb begin
        // Rotate so bit 0 is the pointer position; the lowest set bit is then the winner.
        w_rot   = NUM_REQ'({i_req, i_req} >> i_ptr);
        w_sel   = 0;
        o_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!o_valid && w_rot[k]) begin
                o_valid = 1'b1;
                w_sel   = (32'(i_ptr) + k) % NUM_REQ;
            end
        end
        o_idx = IDX_W'(w_sel);
        o_gnt = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            o_gnt[k] = o_valid && (w_sel == k);
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C command engine among NUM_REQ requesters.
// Optional idle-owner watchdog is compiled in with I2C_CMD_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter
    import i2c_cmd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic [NUM_REQ-1:0]            cmd_valid_i,
    input  logic [3*NUM_REQ-1:0]          cmd_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            cmd_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_nak_o,
    output logic                          rsp_err_o,
    output logic                          eng_cmd_valid_o,
    input  logic                          eng_cmd_ready_i,
    output logic [2:0]                    eng_cmd_o,
    output logic [DATA_WIDTH-1:0]         eng_wdata_o,
    input  logic                          eng_done_i,
    input  logic [DATA_WIDTH-1:0]         eng_rdata_i,
    input  logic                          eng_nak_i,
    input  logic                          eng_al_i
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    typedef logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] wd_cnt_t;

    i2c_arb_state_t  r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt, r_owner, w_owner_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt, r_rsp_valid, w_rsp_valid_nxt;
    logic r_started, w_started_nxt, r_drop, w_drop_nxt, r_eng_valid, w_eng_valid_nxt;
    i2c_cmd_t r_eng_cmd, w_eng_cmd_nxt;
    logic [DATA_WIDTH-1:0] r_eng_wdata, w_eng_wdata_nxt, r_rsp_data, w_rsp_data_nxt;
    logic r_rsp_nak, w_rsp_nak_nxt, r_rsp_err, w_rsp_err_nxt;
`ifdef I2C_CMD_ARB_TIMEOUT_EN
    wd_cnt_t r_wd, w_wd_nxt;
`endif

    logic [NUM_REQ-1:0]    w_pick_oh, w_own_oh, w_cmd_ready;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_valid, w_own_req, w_own_cmd_valid, w_go_force, w_go_release;
    logic [2:0]            w_own_cmd_raw;
    i2c_cmd_t              w_own_cmd;
    logic [DATA_WIDTH-1:0] w_own_wdata;

    i2c_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_own_oh        = '0;
        w_own_req       = 1'b0;
        w_own_cmd_valid = 1'b0;
        w_own_cmd_raw   = '0;
        w_own_wdata     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_own_oh[i]     = 1'b1;
                w_own_req       = req_i[i];
                w_own_cmd_valid = cmd_valid_i[i];
                w_own_cmd_raw   = cmd_i[3*i +: 3];
                w_own_wdata     = wdata_i[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
        w_own_cmd = i2c_cmd_t'(w_own_cmd_raw);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_gnt_nxt       = r_gnt;
        w_started_nxt   = r_started;
        w_drop_nxt      = r_drop;
        w_eng_valid_nxt = r_eng_valid;
        w_eng_cmd_nxt   = r_eng_cmd;
        w_eng_wdata_nxt = r_eng_wdata;
        w_rsp_valid_nxt = '0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_nak_nxt   = r_rsp_nak;
        w_rsp_err_nxt   = r_rsp_err;
        w_cmd_ready     = '0;
        w_go_force      = 1'b0;
        w_go_release    = 1'b0;
`ifdef I2C_CMD_ARB_TIMEOUT_EN
        w_wd_nxt        = '0;
`endif
        case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_gnt_nxt     = w_pick_oh;
                    w_owner_nxt   = w_pick_idx;
                    w_started_nxt = 1'b0;
                    w_drop_nxt    = 1'b0;
                    w_state_nxt   = StOwned;
                end
            end
            StOwned: begin
                // While a command is still being handed to the engine, a req drop is deferred.
                if (r_eng_valid) begin
                    if (!w_own_req) w_drop_nxt = 1'b1;
                    if (eng_cmd_ready_i) begin
                        w_eng_valid_nxt = 1'b0;
                        w_state_nxt     = StWait;
                    end
                end else if (!w_own_req) begin
                    w_go_force = 1'b1;
                end else if (w_own_cmd_valid) begin
                    w_cmd_ready = w_own_oh;
                    if (!r_started && w_own_cmd != CmdStart) begin
                        w_rsp_valid_nxt = w_own_oh;
                        w_rsp_data_nxt  = '0;
                        w_rsp_nak_nxt   = 1'b0;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_eng_valid_nxt = 1'b1;
                        w_eng_cmd_nxt   = w_own_cmd;
                        w_eng_wdata_nxt = w_own_wdata;
                        w_started_nxt   = 1'b1;
                    end
                end
`ifdef I2C_CMD_ARB_TIMEOUT_EN
                else if (r_wd == wd_cnt_t'(TIMEOUT_CYCLES - 1)) begin
                    w_rsp_valid_nxt = w_own_oh;
                    w_rsp_data_nxt  = '0;
                    w_rsp_nak_nxt   = 1'b0;
                    w_rsp_err_nxt   = 1'b1;
                    w_go_force      = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
`endif
            end
            StWait: begin
                if (!w_own_req) w_drop_nxt = 1'b1;
                if (eng_done_i) begin
                    w_rsp_valid_nxt = w_own_oh;
                    w_rsp_data_nxt  = eng_rdata_i;
                    w_rsp_nak_nxt   = eng_nak_i;
                    w_rsp_err_nxt   = eng_al_i;
                    // After arbitration loss the bus is no longer ours, so no STOP is sent.
                    if (eng_al_i || r_eng_cmd == CmdStop) begin
                        w_go_release = 1'b1;
                    end else if (r_drop || !w_own_req) begin
                        w_go_force = 1'b1;
                    end else begin
                        w_state_nxt = StOwned;
                    end
                end
            end
            StForceStop: begin
                if (!r_started) begin
                    w_go_release = 1'b1;
                end else if (r_eng_valid) begin
                    if (eng_cmd_ready_i) w_eng_valid_nxt = 1'b0;
                end else if (eng_done_i) begin
                    w_go_release = 1'b1;
                end
            end
            StRelease: w_state_nxt = StIdle;
            default:   w_state_nxt = StIdle;
        endcase

        if (w_go_force) begin
            w_state_nxt     = StForceStop;
            w_eng_valid_nxt = r_started;
            w_eng_cmd_nxt   = CmdStop;
            w_eng_wdata_nxt = '0;
        end
        if (w_go_release) begin
            w_state_nxt   = StRelease;
            w_gnt_nxt     = '0;
            w_ptr_nxt     = IDX_W'(rr_next(32'(r_owner), NUM_REQ));
            w_started_nxt = 1'b0;
            w_drop_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_gnt       <= '0;
            r_started   <= 1'b0;
            r_drop      <= 1'b0;
            r_eng_valid <= 1'b0;
            r_eng_cmd   <= CmdStart;
            r_eng_wdata <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_nak   <= 1'b0;
            r_rsp_err   <= 1'b0;
`ifdef I2C_CMD_ARB_TIMEOUT_EN
            r_wd        <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_gnt       <= w_gnt_nxt;
            r_started   <= w_started_nxt;
            r_drop      <= w_drop_nxt;
            r_eng_valid <= w_eng_valid_nxt;
            r_eng_cmd   <= w_eng_cmd_nxt;
            r_eng_wdata <= w_eng_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_nak   <= w_rsp_nak_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
`ifdef I2C_CMD_ARB_TIMEOUT_EN
            r_wd        <= w_wd_nxt;
`endif
        end
    end

    assign gnt_o           = r_gnt;
    assign cmd_ready_o     = w_cmd_ready;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_data_o      = r_rsp_data;
    assign rsp_nak_o       = r_rsp_nak;
    assign rsp_err_o       = r_rsp_err;
    assign eng_cmd_valid_o = r_eng_valid;
    assign eng_cmd_o       = r_eng_cmd;
    assign eng_wdata_o     = r_eng_wdata;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed, table-driven bench for i2c_cmd_arbiter with a simple behavioural command engine.
module tb_i2c_cmd_arbiter;

    localparam logic [2:0] C_START = 3'd0, C_STOP = 3'd1, C_WRITE = 3'd2,
                           C_RDACK = 3'd3, C_RDNAK = 3'd4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [3:0]  req_i, gnt_o, cmd_valid_i, cmd_ready_o, rsp_valid_o;
    logic [11:0] cmd_i;
    logic [31:0] wdata_i;
    logic [7:0]  rsp_data_o, eng_wdata_o, eng_rdata_i;
    logic        rsp_nak_o, rsp_err_o, eng_cmd_valid_o, eng_cmd_ready_i;
    logic [2:0]  eng_cmd_o;
    logic        eng_done_i, eng_nak_i, eng_al_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] log_cmd[$];
    logic [7:0] log_wd[$];
    logic [7:0] eng_rdata_v = '0;
    logic       eng_nak_v = 1'b0, eng_al_v = 1'b0;
    int         eng_lat = 2;

    i2c_cmd_arbiter dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .req_i           (req_i),
        .gnt_o           (gnt_o),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_i           (cmd_i),
        .wdata_i         (wdata_i),
        .cmd_ready_o     (cmd_ready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_nak_o       (rsp_nak_o),
        .rsp_err_o       (rsp_err_o),
        .eng_cmd_valid_o (eng_cmd_valid_o),
        .eng_cmd_ready_i (eng_cmd_ready_i),
        .eng_cmd_o       (eng_cmd_o),
        .eng_wdata_o     (eng_wdata_o),
        .eng_done_i      (eng_done_i),
        .eng_rdata_i     (eng_rdata_i),
        .eng_nak_i       (eng_nak_i),
        .eng_al_i        (eng_al_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) if (rst_n_i === 1'b1) chk("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);

    // Engine model: accept one command, then complete it eng_lat cycles later.
    initial begin
        eng_cmd_ready_i = 1'b0;
        eng_done_i      = 1'b0;
        eng_rdata_i     = '0;
        eng_nak_i       = 1'b0;
        eng_al_i        = 1'b0;
        forever begin
            @(negedge clk_i);
            if (eng_cmd_valid_o === 1'b1 && rst_n_i === 1'b1) begin
                log_cmd.push_back(eng_cmd_o);
                log_wd.push_back(eng_wdata_o);
                eng_cmd_ready_i = 1'b1;
                @(negedge clk_i);
                eng_cmd_ready_i = 1'b0;
                repeat (eng_lat) @(negedge clk_i);
                eng_rdata_i = eng_rdata_v;
                eng_nak_i   = eng_nak_v;
                eng_al_i    = eng_al_v;
                eng_done_i  = 1'b1;
                @(negedge clk_i);
                eng_done_i  = 1'b0;
                eng_rdata_i = '0;
                eng_nak_i   = 1'b0;
                eng_al_i    = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic acquire(input int idx);
        logic [3:0] oh;
        bit got;
        oh = 4'b1 << idx;
        req_i[idx] = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk_i);
            if (gnt_o != 0) got = 1;
        end
        chk($sformatf("grant%0d", idx), 32'(gnt_o), 32'(oh));
    endtask

    // Called on a negedge; returns on the negedge where the response is visible.
    task automatic do_cmd(input int idx, input logic [2:0] c, input logic [7:0] wd,
                          input logic [7:0] rd, input logic nak, input logic al,
                          input logic fwd, input logic e_err, input logic e_nak,
                          input logic [7:0] e_data, input string name);
        logic [3:0] oh;
        int n0;
        bit got;
        oh = 4'b1 << idx;
        n0 = log_cmd.size();
        eng_rdata_v = rd;
        eng_nak_v   = nak;
        eng_al_v    = al;
        cmd_valid_i[idx] = 1'b1;
        cmd_i[idx*3 +: 3] = c;
        wdata_i[idx*8 +: 8] = wd;
        #1;
        chk({name, "_ready"}, 32'(cmd_ready_o), 32'(oh));
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i[idx] = 1'b0;
        got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            if (rsp_valid_o != 0) got = 1;
            else @(negedge clk_i);
        end
        chk({name, "_rsp_valid"}, 32'(rsp_valid_o), 32'(oh));
        chk({name, "_rsp_err"}, 32'(rsp_err_o), 32'(e_err));
        chk({name, "_rsp_nak"}, 32'(rsp_nak_o), 32'(e_nak));
        chk({name, "_rsp_data"}, 32'(rsp_data_o), 32'(e_data));
        if (fwd) begin
            chk({name, "_fwd_count"}, 32'(log_cmd.size()), 32'(n0 + 1));
            if (log_cmd.size() == n0 + 1) begin
                chk({name, "_fwd_cmd"}, 32'(log_cmd[n0]), 32'(c));
                chk({name, "_fwd_wdata"}, 32'(log_wd[n0]), 32'(wd));
            end
        end else begin
            chk({name, "_not_fwd"}, 32'(log_cmd.size()), 32'(n0));
        end
    endtask

    typedef struct {
        int         req;
        logic [2:0] cmd;
        logic [7:0] wd;
        logic [7:0] rd;
        logic       nak;
        logic       al;
        logic       acq;
        logic       rel;
        logic       fwd;
        logic       e_err;
        logic       e_nak;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[10];
    vec_t v;
    int   n_tmp, n_rsp, n_gnt;

    initial begin
        vecs[0] = '{0, C_START, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{0, C_WRITE, 8'h84, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{0, C_WRITE, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{0, C_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{2, C_START, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{2, C_WRITE, 8'h45, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[6] = '{2, C_RDNAK, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[7] = '{2, C_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[8] = '{3, C_WRITE, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[9] = '{3, C_START, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

        rst_n_i = 1'b0;
        req_i = '0;
        cmd_valid_i = '0;
        cmd_i = '0;
        wdata_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_gnt", 32'(gnt_o), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_eng_valid", 32'(eng_cmd_valid_o), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready_o), 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            if (v.acq) acquire(v.req);
            do_cmd(v.req, v.cmd, v.wd, v.rd, v.nak, v.al, v.fwd, v.e_err, v.e_nak, v.e_data,
                   $sformatf("vec%0d", i));
            if (v.rel) begin
                req_i[v.req] = 1'b0;
                n_tmp = log_cmd.size();
                @(negedge clk_i);
                chk($sformatf("vec%0d_released", i), 32'(gnt_o), 32'd0);
                repeat (3) @(negedge clk_i);
                chk($sformatf("vec%0d_no_stop", i), 32'(log_cmd.size()), 32'(n_tmp));
            end
        end

        // Contention: all four request together with the pointer at 0.
        req_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            n_gnt = 0;
            for (int t = 0; t < 20 && n_gnt == 0; t++) begin
                @(negedge clk_i);
                if (gnt_o != 0) n_gnt = 1;
            end
            chk($sformatf("rr_grant%0d", k), 32'(gnt_o), 32'(4'b1 << k));
            if (k == 0) begin
                cmd_valid_i[1] = 1'b1;
                cmd_i[5:3] = C_START;
                #1;
                chk("nonowner_ready", 32'(cmd_ready_o), 32'd0);
                @(negedge clk_i);
                chk("nonowner_not_fwd", 32'(eng_cmd_valid_o), 32'd0);
                cmd_valid_i[1] = 1'b0;
            end
            do_cmd(k, C_START, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00,
                   $sformatf("rr%0d_start", k));
            do_cmd(k, C_STOP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00,
                   $sformatf("rr%0d_stop", k));
            req_i[k] = 1'b0;
            @(negedge clk_i);
            chk($sformatf("rr%0d_gap", k), 32'(gnt_o), 32'd0);
        end

        // Abandon: owner 1 drops req while its WRITE is outstanding.
        repeat (2) @(negedge clk_i);
        acquire(1);
        do_cmd(1, C_START, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "ab_start");
        n_tmp = log_cmd.size();
        eng_rdata_v = '0;
        eng_nak_v = 1'b0;
        eng_al_v = 1'b0;
        cmd_valid_i[1] = 1'b1;
        cmd_i[5:3] = C_WRITE;
        wdata_i[15:8] = 8'h3C;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i[1] = 1'b0;
        req_i[1] = 1'b0;
        n_rsp = 0;
        for (int t = 0; t < 40 && n_rsp == 0; t++) begin
            if (rsp_valid_o != 0) n_rsp = 1;
            else @(negedge clk_i);
        end
        chk("ab_write_rsp", 32'(rsp_valid_o), 32'h2);
        chk("ab_write_err", 32'(rsp_err_o), 32'd0);
        n_rsp = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk_i);
            if (rsp_valid_o != 0) n_rsp++;
        end
        chk("ab_no_stop_rsp", 32'(n_rsp), 32'd0);
        chk("ab_cmd_count", 32'(log_cmd.size()), 32'(n_tmp + 2));
        chk("ab_last_is_stop", 32'(log_cmd[log_cmd.size()-1]), 32'(C_STOP));
        chk("ab_released", 32'(gnt_o), 32'd0);

        // Reset during an outstanding READ_ACK; the late completion must be ignored.
        acquire(0);
        do_cmd(0, C_START, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "rst_start");
        eng_lat = 10;
        eng_rdata_v = 8'h77;
        cmd_valid_i[0] = 1'b1;
        cmd_i[2:0] = C_RDACK;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i[0] = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b0;
        req_i = '0;
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_eng_valid", 32'(eng_cmd_valid_o), 32'd0);
        chk("rst_eng_cmd", 32'(eng_cmd_o), 32'd0);
        chk("rst_rsp_flags", 32'({rsp_nak_o, rsp_err_o}), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        n_rsp = 0;
        n_gnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk_i);
            if (rsp_valid_o != 0) n_rsp++;
            if (gnt_o != 0) n_gnt++;
        end
        chk("late_done_no_rsp", 32'(n_rsp), 32'd0);
        chk("late_done_no_gnt", 32'(n_gnt), 32'd0);
        chk("late_done_data", 32'(rsp_data_o), 32'd0);
        eng_lat = 2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
